// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's pipeline-control, instruction-memory and IF/ID signals.
// The master side is the fetch stage; the slave side is the surrounding pipeline/memory.
interface fetch_stage_if #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32
);
   logic              stall_i;
   logic              flush_i;
   logic [ADDR_W-1:0] branch_pc_i;
   logic              imem_req_o;
   logic [ADDR_W-1:0] imem_addr_o;
   logic              imem_ack_i;
   logic [INST_W-1:0] imem_data_i;
   logic [ADDR_W-1:0] pc_o;
   logic [ADDR_W-1:0] IF_ID_pc_o;
   logic [INST_W-1:0] IF_ID_inst_o;
   logic              IF_ID_valid_o;
   logic              fetch_busy_o;

   modport master (
      input  stall_i, flush_i, branch_pc_i, imem_ack_i, imem_data_i,
      output imem_req_o, imem_addr_o, pc_o, IF_ID_pc_o, IF_ID_inst_o,
             IF_ID_valid_o, fetch_busy_o
   );

   modport slave (
      output stall_i, flush_i, branch_pc_i, imem_ack_i, imem_data_i,
      input  imem_req_o, imem_addr_o, pc_o, IF_ID_pc_o, IF_ID_inst_o,
             IF_ID_valid_o, fetch_busy_o
   );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage with IF/ID register, skid buffer for stalled acks
// and a redirect state that drains a stale outstanding fetch after a branch flush.
module fetch_stage #(
   parameter int                ADDR_W   = 32,
   parameter int                INST_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic         clk_i,
   input logic         rst_i,
   fetch_stage_if.master bus
);
   typedef enum logic [1:0] {FETCH, HOLD, REDIRECT} state_t;

   state_t            state, state_n;
   logic [ADDR_W-1:0] pc, pc_n;
   logic [ADDR_W-1:0] if_id_pc, if_id_pc_n;
   logic [INST_W-1:0] if_id_inst, if_id_inst_n;
   logic              if_id_valid, if_id_valid_n;
   logic [INST_W-1:0] skid, skid_n;
   logic [ADDR_W-1:0] stale_addr, stale_addr_n;
   logic [ADDR_W-1:0] pc_plus4;

   assign pc_plus4 = pc + ADDR_W'(4);

   // NOTE: every state register, including the skid word, has a reset value so
   // no X can leak onto IF/ID even though the skid content is gated by state.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         if_id_pc    <= '0;
         if_id_inst  <= '0;
         if_id_valid <= 1'b0;
         skid        <= '0;
         stale_addr  <= '0;
      end else begin
         // NOTE: non-blocking assignments so all registers update from the same
         // pre-edge values regardless of statement order.
         state       <= state_n;
         pc          <= pc_n;
         if_id_pc    <= if_id_pc_n;
         if_id_inst  <= if_id_inst_n;
         if_id_valid <= if_id_valid_n;
         skid        <= skid_n;
         stale_addr  <= stale_addr_n;
      end
   end

   always_comb begin
      // NOTE: every variable is defaulted to its held value first, so no path
      // through the case leaves one unassigned and no latch is inferred.
      state_n       = state;
      pc_n          = pc;
      if_id_pc_n    = if_id_pc;
      if_id_inst_n  = if_id_inst;
      if_id_valid_n = if_id_valid;
      skid_n        = skid;
      stale_addr_n  = stale_addr;

      if (bus.flush_i) begin
         pc_n          = bus.branch_pc_i;
         if_id_inst_n  = '0;
         if_id_valid_n = 1'b0;
         unique case (state)
            FETCH: begin
               if (!bus.imem_ack_i) begin
                  stale_addr_n = pc;
                  state_n      = REDIRECT;
               end else begin
                  state_n = FETCH;
               end
            end
            // A stale ack landing with a repeated flush completes the drain.
            REDIRECT: state_n = bus.imem_ack_i ? FETCH : REDIRECT;
            default:  state_n = FETCH;
         endcase
      end else begin
         unique case (state)
            FETCH: begin
               if (bus.imem_ack_i) begin
                  if (bus.stall_i) begin
                     skid_n  = bus.imem_data_i;
                     state_n = HOLD;
                  end else begin
                     if_id_pc_n    = pc_plus4;
                     if_id_inst_n  = bus.imem_data_i;
                     if_id_valid_n = 1'b1;
                     pc_n          = pc_plus4;
                  end
               end else if (!bus.stall_i) begin
                  if_id_inst_n  = '0;
                  if_id_valid_n = 1'b0;
               end
            end
            HOLD: begin
               // Acks here are protocol errors: req is low, so they are ignored.
               if (!bus.stall_i) begin
                  if_id_pc_n    = pc_plus4;
                  if_id_inst_n  = skid;
                  if_id_valid_n = 1'b1;
                  pc_n          = pc_plus4;
                  state_n       = FETCH;
               end
            end
            REDIRECT: begin
               if (bus.imem_ack_i) state_n = FETCH;
            end
            default: state_n = FETCH;
         endcase
      end
   end

   assign bus.imem_req_o    = (state == FETCH) || (state == REDIRECT);
   assign bus.imem_addr_o   = (state == REDIRECT) ? stale_addr : pc;
   assign bus.fetch_busy_o  = ((state == FETCH) && !bus.imem_ack_i) || (state == REDIRECT);
   assign bus.pc_o          = pc;
   assign bus.IF_ID_pc_o    = if_id_pc;
   assign bus.IF_ID_inst_o  = if_id_inst;
   assign bus.IF_ID_valid_o = if_id_valid;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: the bench plays the instruction memory by hand,
// cycle by cycle, and checks IF/ID, PC and handshake outputs against fixed values.
module tb_fetch_stage;
   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   fetch_stage_if #(.ADDR_W(32), .INST_W(32)) bus ();

   fetch_stage #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Drive one cycle's inputs half a period before the next rising edge.
   task automatic drive(input logic stall, input logic flush, input logic [31:0] bpc,
                        input logic ack, input logic [31:0] data);
      @(negedge clk);
      bus.stall_i     = stall;
      bus.flush_i     = flush;
      bus.branch_pc_i = bpc;
      bus.imem_ack_i  = ack;
      bus.imem_data_i = data;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_ifid(input string tag, input logic [31:0] ipc, input logic [31:0] inst,
                             input logic valid, input logic [31:0] pc);
      check({tag, "_ifid_pc"},    bus.IF_ID_pc_o, ipc);
      check({tag, "_ifid_inst"},  bus.IF_ID_inst_o, inst);
      check({tag, "_ifid_valid"}, {31'b0, bus.IF_ID_valid_o}, {31'b0, valid});
      check({tag, "_pc"},         bus.pc_o, pc);
   endtask

   task automatic check_req(input string tag, input logic req, input logic [31:0] addr,
                            input logic busy);
      check({tag, "_req"},  {31'b0, bus.imem_req_o}, {31'b0, req});
      if (req) check({tag, "_addr"}, bus.imem_addr_o, addr);
      check({tag, "_busy"}, {31'b0, bus.fetch_busy_o}, {31'b0, busy});
   endtask

   initial begin
      rst_n           = 1'b0;
      bus.stall_i     = 1'b0;
      bus.flush_i     = 1'b0;
      bus.branch_pc_i = '0;
      bus.imem_ack_i  = 1'b0;
      bus.imem_data_i = '0;
      #1;
      check_ifid("reset", 32'h0, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_req("after_reset", 1'b1, 32'h0, 1'b1);

      // Back-to-back fetches from a 1-cycle memory.
      drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h8C220004);
      check_req("f0", 1'b1, 32'h0, 1'b0);
      tick();
      check_ifid("f0", 32'h4, 32'h8C220004, 1'b1, 32'h4);
      drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h00221820);
      check_req("f1", 1'b1, 32'h4, 1'b0);
      tick();
      check_ifid("f1", 32'h8, 32'h00221820, 1'b1, 32'h8);

      // Ack at 0x8 while stalled for three cycles; a stray ack during HOLD is ignored.
      drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h01234567);
      check_req("st0", 1'b1, 32'h8, 1'b0);
      tick();
      check_ifid("st0", 32'h8, 32'h00221820, 1'b1, 32'h8);
      drive(1'b1, 1'b0, 32'h0, 1'b1, 32'hBADBAD00);
      check_req("st1", 1'b0, 32'h0, 1'b0);
      tick();
      check_ifid("st1", 32'h8, 32'h00221820, 1'b1, 32'h8);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      check_req("st2", 1'b0, 32'h0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      check_req("st_rel", 1'b0, 32'h0, 1'b0);
      tick();
      check_ifid("st_rel", 32'hC, 32'h01234567, 1'b1, 32'hC);

      // Three-cycle memory latency at 0xC.
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      check_req("lat0", 1'b1, 32'hC, 1'b1);
      tick();
      check_ifid("lat0", 32'hC, 32'h0, 1'b0, 32'hC);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      check_req("lat1", 1'b1, 32'hC, 1'b1);
      tick();
      check_ifid("lat1", 32'hC, 32'h0, 1'b0, 32'hC);
      drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hAAAA0001);
      check_req("lat2", 1'b1, 32'hC, 1'b0);
      tick();
      check_ifid("lat2", 32'h10, 32'hAAAA0001, 1'b1, 32'h10);

      // Flush to 0x40 while the fetch at 0x10 is outstanding.
      drive(1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
      tick();
      check_ifid("rd0", 32'h10, 32'h0, 1'b0, 32'h40);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      check_req("rd1", 1'b1, 32'h10, 1'b1);
      tick();
      check_ifid("rd1", 32'h10, 32'h0, 1'b0, 32'h40);
      drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF);
      check_req("rd2", 1'b1, 32'h10, 1'b1);
      tick();
      check_ifid("rd2", 32'h10, 32'h0, 1'b0, 32'h40);
      drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h11112222);
      check_req("rd3", 1'b1, 32'h40, 1'b0);
      tick();
      check_ifid("rd3", 32'h44, 32'h11112222, 1'b1, 32'h44);

      // Flush and stall together while HOLD has a skid word.
      drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h33334444);
      tick();
      drive(1'b1, 1'b1, 32'h100, 1'b0, 32'h0);
      check_req("fs0", 1'b0, 32'h0, 1'b0);
      tick();
      check_ifid("fs0", 32'h44, 32'h0, 1'b0, 32'h100);
      drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h55556666);
      check_req("fs1", 1'b1, 32'h100, 1'b0);
      tick();
      check_ifid("fs1", 32'h104, 32'h55556666, 1'b1, 32'h104);

      // Flush with ack in FETCH goes straight to FETCH; PC wraps past the top.
      drive(1'b0, 1'b1, 32'hFFFFFFFC, 1'b1, 32'h77778888);
      tick();
      check_ifid("wr0", 32'h104, 32'h0, 1'b0, 32'hFFFFFFFC);
      drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h9999AAAA);
      check_req("wr1", 1'b1, 32'hFFFFFFFC, 1'b0);
      tick();
      check_ifid("wr1", 32'h0, 32'h9999AAAA, 1'b1, 32'h0);

      // Asynchronous reset with a fetch at 0x20 outstanding.
      drive(1'b0, 1'b1, 32'h20, 1'b1, 32'h0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      check_req("ar0", 1'b1, 32'h20, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_ifid("ar_async", 32'h0, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_req("ar_rel", 1'b1, 32'h0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
